spi_ram_master: RTL and testbench
=================================

# spi_ram_master

SPI master and two-port request arbiter that sequences byte-wide RAM accesses onto the SPI slave/RAM wrapper. Two requesters (e.g. bench driver and a DMA-style engine) issue write or read requests. The block arbitrates round-robin and serializes each request into the 11-bit frame protocol: 3-bit command, MSB first, then 8-bit payload. For reads it captures the 8-bit MISO reply and returns it tagged with the requester ID.

## Interface
- RD_LAT, 2: clocks between the last MOSI bit of a 111 frame and the first valid MISO bit.
- SS_GAP, 1: minimum SS_n-high clocks between frames (1..15).
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid&ready).
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  8  RAM address.
- req0_wdata / req1_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_id  out  1  requester that owns the completion.
- rsp_we  out  1  completed op was a write.
- rsp_rdata  out  8  read data; 0 for writes.
- MOSI  out  1  serial data to slave.
- SS_n  out  1  slave select, active low.
- MISO  in  1  serial data from slave.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, SHIFT, WAIT_RD, CAPTURE, GAP.
- Frames are fixed per request type:
  - Write: 000+addr, then 001+wdata.
  - Read: 110+addr, then 111+8'h00. After the 111 frame, MISO carries the read byte.
- IDLE: ready is asserted only to the granted requester with valid high.
  - The accepted request (we, addr, wdata, id) is latched and frame index is set to 0.
  - Next state is SHIFT.
- Arbitration is round-robin with a 1-bit pointer; reset gives priority to requester 0.
  - If both are valid, the pointer side wins and the pointer then flips to the other side.
  - If one is valid, it wins and the pointer moves to the non-winner.
- SHIFT: SS_n=0 and an 11-bit shift register drives MOSI MSB first, with an 11-count bit counter.
  - Frame 0 done: go to GAP.
  - Frame 1 of a write done: go to GAP.
  - Frame 1 of a read done: go to WAIT_RD, with SS_n held low.
- WAIT_RD: count RD_LAT cycles, then go to CAPTURE.
- CAPTURE: shift MISO into rdata MSB first for 8 cycles, then go to GAP.
- GAP: SS_n=1 for SS_GAP cycles.
  - After frame 0: go back to SHIFT with frame index 1.
  - After the final frame: pulse rsp_valid and go to IDLE.
- MOSI=0 whenever SS_n=1.
- Reset values: SS_n=1, MOSI=0, ready=0, rsp_valid=0, rsp_id=0, rsp_we=0, rsp_rdata=0, busy=0, pointer=0.
- Reset mid-transaction: abort immediately (SS_n rises asynchronously), drop the latched request, emit no rsp.

## Timing
- Accept at cycle T (ready high). SS_n falls and MOSI=bit10 at T+1; bit0 is at T+11.
- Write: frame 1 bits occupy T+12+SS_GAP .. T+22+SS_GAP.
  - rsp_valid on the cycle after the final GAP, at T+23+2·SS_GAP.
  - IDLE is reached with it; the next accept is possible the same cycle.
- Read: last 111 bit at cycle E = T+22+SS_GAP.
  - MISO is sampled at E+RD_LAT+1 .. E+RD_LAT+8.
  - rsp_valid at E+RD_LAT+9+SS_GAP.
- Outputs are registered; ready is combinational from state, valid and pointer.
- A request whose valid drops before acceptance is never started.

## Configuration
- SPI_RAM_MASTER_ADDR_CACHE_EN: tracks last_wr_addr and last_rd_addr, each with a valid bit cleared on reset.
  - With the macro defined, frame 0 is skipped when the new request's address equals the cached address of the same type: SHIFT starts directly at frame 1.
  - Write latency is then reduced by 11+SS_GAP cycles.
  - Without the macro, every request always sends both frames.

## Test plan
- After reset, req0 write addr=8'h3C data=8'hA5 -> MOSI frames 000_00111100, gap, 001_10100101. rsp_valid at T+25 (SS_GAP=1) with rsp_id=0 and rsp_we=1.
- Read addr=8'h3C with the slave model returning 8'hA5 -> 110_00111100, then 111_00000000. MISO sampled per RD_LAT=2; rsp_rdata=8'hA5, rsp_id matches.
- req0 and req1 valid in the same cycle, held for 4 requests -> grants alternate 0,1,0,1. No frames overlap, and each rsp_id matches its grant.
- Assert rst_n=0 mid-CAPTURE -> SS_n=1 and MOSI=0 immediately. No rsp_valid; after release, req0 has priority.
- Only req1 valid, 3 back-to-back writes -> req1 is granted each time. Next accept occurs on the rsp_valid cycle.
- With SPI_RAM_MASTER_ADDR_CACHE_EN, two writes to addr 8'h10 -> the second sends only the 001 frame, and its rsp arrives 12 cycles earlier. A read from 8'h10 still sends the 110 frame.

Source files
------------

// File: rtl/spi_ram_master.sv
// spi_ram_master: round-robin two-port arbiter serialising RAM accesses into 11-bit SPI frames.
// Optional SPI_RAM_MASTER_ADDR_CACHE_EN skips the address frame on a repeated same-type address.
module spi_ram_master #(
  parameter int RD_LAT = 2,
  parameter int SS_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_we,
  output logic [7:0] rsp_rdata,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, SHIFT, WAIT_RD, CAPTURE, GAP
  } state_e;

  localparam logic [3:0] GAP_LD = 4'(SS_GAP - 1);
  localparam logic [3:0] LAT_LD =
    (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        we_q, we_d;
  logic        id_q, id_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        frame_q, frame_d;
  logic [10:0] sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_we_q, rsp_we_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        mosi_q, mosi_d;
  logic        ss_n_q, ss_n_d;
  logic        busy_q, busy_d;

  logic        gnt, accept, hit;
  logic        sel_we;
  logic [7:0]  sel_addr, sel_wdata;

  function automatic logic [10:0] frame0(
    input logic we, input logic [7:0] a);
    return {(we ? 3'b000 : 3'b110), a};
  endfunction

  function automatic logic [10:0] frame1(
    input logic we, input logic [7:0] d);
    return we ? {3'b001, d} : {3'b111, 8'h00};
  endfunction

  // With both valid the pointer side wins; otherwise the lone requester
  assign gnt = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  assign accept = (state_q == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept & gnt;
  assign sel_we = gnt ? req1_we : req0_we;
  assign sel_addr = gnt ? req1_addr : req0_addr;
  assign sel_wdata = gnt ? req1_wdata : req0_wdata;

`ifdef SPI_RAM_MASTER_ADDR_CACHE_EN
  logic [7:0] wr_addr_q, rd_addr_q;
  logic       wr_v_q, rd_v_q;

  assign hit = sel_we ? (wr_v_q && wr_addr_q == sel_addr)
                      : (rd_v_q && rd_addr_q == sel_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= 8'h00;
      rd_addr_q <= 8'h00;
      wr_v_q <= 1'b0;
      rd_v_q <= 1'b0;
    end else if (accept) begin
      if (sel_we) begin
        wr_addr_q <= sel_addr;
        wr_v_q <= 1'b1;
      end else begin
        rd_addr_q <= sel_addr;
        rd_v_q <= 1'b1;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    we_d = we_q;
    id_d = id_q;
    wdata_d = wdata_q;
    frame_d = frame_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_id_d = rsp_id_q;
    rsp_we_d = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d = ~gnt;
          we_d = sel_we;
          id_d = gnt;
          wdata_d = sel_wdata;
          frame_d = hit;
          sh_d = hit ? frame1(sel_we, sel_wdata)
                     : frame0(sel_we, sel_addr);
          cnt_d = 4'd10;
          rdata_d = 8'h00;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (!frame_q || we_q) begin
            state_d = GAP;
            cnt_d = GAP_LD;
          end else if (RD_LAT == 0) begin
            state_d = CAPTURE;
            cnt_d = 4'd7;
          end else begin
            state_d = WAIT_RD;
            cnt_d = LAT_LD;
          end
        end else begin
          sh_d = {sh_q[9:0], 1'b0};
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT_RD: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
          cnt_d = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        rdata_d = {rdata_q[6:0], MISO};
        if (cnt_q == 4'd0) begin
          state_d = GAP;
          cnt_d = GAP_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!frame_q) begin
          frame_d = 1'b1;
          sh_d = frame1(we_q, wdata_q);
          cnt_d = 4'd10;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
          rsp_valid_d = 1'b1;
          rsp_id_d = id_q;
          rsp_we_d = we_q;
          rsp_rdata_d = we_q ? 8'h00 : rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // SS_n stays low from the read frame through the MISO reply
    ss_n_d = ~(state_d inside {SHIFT, WAIT_RD, CAPTURE});
    mosi_d = (state_d == SHIFT) & sh_d[10];
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      we_q <= 1'b0;
      id_q <= 1'b0;
      wdata_q <= 8'h00;
      frame_q <= 1'b0;
      sh_q <= 11'h000;
      cnt_q <= 4'd0;
      rdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_we_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      mosi_q <= 1'b0;
      ss_n_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      we_q <= we_d;
      id_q <= id_d;
      wdata_q <= wdata_d;
      frame_q <= frame_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_we_q <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      mosi_q <= mosi_d;
      ss_n_q <= ss_n_d;
      busy_q <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_we = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign MOSI = mosi_q;
  assign SS_n = ss_n_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: directed vector bench for spi_ram_master
// covering frames, timing, arbitration, reset abort and address cache.
module tb_spi_ram_master;

  localparam int RD_LAT = 2;
  localparam int SS_GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, req0_we;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp_valid, rsp_id, rsp_we;
  logic [7:0] rsp_rdata;
  logic       MOSI, SS_n, MISO, busy;

  int errs = 0;
  int checks = 0;

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] miso;
    logic [7:0] exp_rdata;
  } vec_t;

  spi_ram_master #(.RD_LAT(RD_LAT), .SS_GAP(SS_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic v, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    if (port == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic rdy(input int port);
    return (port == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic run_req(input vec_t v, input bit skip0, input bit b2b);
    logic [10:0] f0, f1, g0, g1;
    logic ss_bad, early;
    int t;
    f0 = {(v.we ? 3'b000 : 3'b110), v.addr};
    f1 = v.we ? {3'b001, v.wdata} : {3'b111, 8'h00};
    g0 = '0;
    g1 = '0;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    #1;
    t = 0;
    while (!rdy(v.port) && t < 200) begin
      step();
      t++;
    end
    if (!rdy(v.port)) begin
      chk("accept_timeout", 0, 1);
      drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
      return;
    end
    if (b2b) chk("b2b_accept_delay", t, 0);
    step();
    drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    ss_bad = 1'b0;
    early = 1'b0;
    if (!skip0) begin
      for (int i = 10; i >= 0; i--) begin
        if (i != 10) step();
        g0[i] = MOSI;
        ss_bad |= SS_n;
        early |= rsp_valid;
      end
      chk("frame0", g0, f0);
      for (int k = 0; k < SS_GAP; k++) begin
        step();
        ss_bad |= ~SS_n | MOSI;
        early |= rsp_valid;
      end
      step();
    end
    for (int i = 10; i >= 0; i--) begin
      if (i != 10) step();
      g1[i] = MOSI;
      ss_bad |= SS_n;
      early |= rsp_valid;
    end
    chk("frame1", g1, f1);
    if (!v.we) begin
      for (int k = 0; k < RD_LAT; k++) begin
        step();
        ss_bad |= SS_n | MOSI;
        early |= rsp_valid;
      end
      for (int i = 7; i >= 0; i--) begin
        step();
        MISO = v.miso[i];
        ss_bad |= SS_n | MOSI;
        early |= rsp_valid;
      end
    end
    for (int k = 0; k < SS_GAP; k++) begin
      step();
      MISO = 1'b0;
      ss_bad |= ~SS_n | MOSI;
      early |= rsp_valid;
    end
    step();
    chk("ss_mosi_shape", ss_bad, 0);
    chk("no_early_rsp", early, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.port);
    chk("rsp_we", rsp_we, v.we);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("busy_idle", busy, 0);
  endtask

  vec_t vecs[5];
  vec_t v;
  int   t, g;
  logic bad;
  bit   cache_en;

  initial begin
`ifdef SPI_RAM_MASTER_ADDR_CACHE_EN
    cache_en = 1'b1;
`else
    cache_en = 1'b0;
`endif
    vecs[0] = '{0, 1'b1, 8'h3C, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{0, 1'b0, 8'h3C, 8'h00, 8'hA5, 8'hA5};
    vecs[2] = '{1, 1'b0, 8'h5A, 8'h00, 8'h3C, 8'h3C};
    vecs[3] = '{1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{0, 1'b0, 8'h00, 8'h00, 8'h81, 8'h81};

    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    MISO = 1'b0;
    repeat (3) step();
    chk("rst_SS_n", SS_n, 1);
    chk("rst_MOSI", MOSI, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_req(vecs[i], 1'b0, 1'b0);

    // Reset in the middle of a read capture
    drive(0, 1'b1, 1'b0, 8'h77, 8'h00);
    #1;
    t = 0;
    while (!req0_ready && t < 200) begin step(); t++; end
    chk("rst_test_accept", req0_ready, 1);
    step();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (27) step();
    MISO = 1'b1;
    chk("pre_rst_SS_n", SS_n, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_SS_n", SS_n, 1);
    chk("abort_MOSI", MOSI, 0);
    chk("abort_busy", busy, 0);
    repeat (2) step();
    rst_n = 1'b1;
    MISO = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      bad |= rsp_valid | ~SS_n;
    end
    chk("abort_no_rsp", bad, 0);

    // Both held valid: grants alternate starting from requester 0
    drive(0, 1'b1, 1'b1, 8'h01, 8'h11);
    drive(1, 1'b1, 1'b1, 8'h02, 8'h22);
    #1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!(req0_ready | req1_ready) && t < 200) begin
        step();
        t++;
      end
      chk("arb_any_grant", req0_ready | req1_ready, 1);
      chk("arb_one_grant", req0_ready & req1_ready, 0);
      chk("arb_grant_id", req1_ready, k % 2);
      g = int'(req1_ready);
      step();
      if (k == 3) begin
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      t = 1;
      while (!rsp_valid && t < 200) begin step(); t++; end
      chk("arb_rsp_latency", t, 23 + 2 * SS_GAP);
      chk("arb_rsp_id", rsp_id, g);
    end

    // Lone requester 1, back-to-back writes
    v = '{1, 1'b1, 8'h20, 8'hA1, 8'h00, 8'h00};
    run_req(v, 1'b0, 1'b0);
    v = '{1, 1'b1, 8'h21, 8'hB2, 8'h00, 8'h00};
    run_req(v, 1'b0, 1'b1);
    v = '{1, 1'b1, 8'h22, 8'hC3, 8'h00, 8'h00};
    run_req(v, 1'b0, 1'b1);

    // Repeated write address, then a read of the same address
    v = '{0, 1'b1, 8'h10, 8'h55, 8'h00, 8'h00};
    run_req(v, 1'b0, 1'b0);
    v = '{0, 1'b1, 8'h10, 8'h66, 8'h00, 8'h00};
    run_req(v, cache_en, 1'b0);
    v = '{0, 1'b0, 8'h10, 8'h00, 8'h5A, 8'h5A};
    run_req(v, 1'b0, 1'b0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
